// File: rtl/debounce_pkg.sv
// Shared types and helpers for the debounce_edge block.
// Glitch statistics are enabled at build time with DEBOUNCE_GLITCH_STATS_EN.
package debounce_pkg;

    typedef enum logic [1:0] {
        S_LOW      = 2'd0,
        S_CHK_HIGH = 2'd1,
        S_HIGH     = 2'd2,
        S_CHK_LOW  = 2'd3
    } state_t;

    localparam int GLITCH_CNT_W = 8;

    // Debounced level presented while in a given state.
    function automatic logic level_of(input state_t s);
        return (s == S_HIGH) || (s == S_CHK_LOW);
    endfunction

    function automatic logic is_chk(input state_t s);
        return (s == S_CHK_HIGH) || (s == S_CHK_LOW);
    endfunction

endpackage

// File: rtl/debounce_edge_cnt.sv
// Stability counter for debounce_edge: clear, increment and terminal flag.
module debounce_cnt #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic i_clk,
    input  logic i_arst,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_term
);

    logic [CNT_W-1:0] cnt_q;

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every flop samples the pre-edge value of its neighbours.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            cnt_q <= '0;
        end else if (i_clr) begin
            cnt_q <= '0;
        end else if (i_inc) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign o_term = (cnt_q == CNT_W'(STABLE_CYCLES - 1));

endmodule

// File: rtl/debounce_edge.sv
// Glitch filter with registered level and single-cycle rise/fall pulses.
// Define DEBOUNCE_GLITCH_STATS_EN to build the saturating glitch counter.
module debounce_edge
    import debounce_pkg::*;
#(
    parameter int   STABLE_CYCLES = 4,
    parameter logic RST_LEVEL     = 1'b0
) (
    input  logic                    i_clk,
    input  logic                    i_arst,
    input  logic                    i_synced_bit,
    input  logic                    i_en,
    output logic                    o_level,
    output logic                    o_rise,
    output logic                    o_fall,
    output logic [GLITCH_CNT_W-1:0] o_glitch_cnt
);

    localparam int     CNT_W     = $clog2(STABLE_CYCLES + 1);
    localparam state_t RST_STATE = RST_LEVEL ? S_HIGH : S_LOW;

    if (STABLE_CYCLES < 1 || STABLE_CYCLES > 65535) begin : g_bad_stable_cycles
        $error("debounce_edge: STABLE_CYCLES must be within 1..65535");
    end

    state_t state_q, state_d;
    logic   cnt_term, cnt_inc, cnt_clr;
    logic   level_d, rise_d, fall_d;

    debounce_cnt #(
        .STABLE_CYCLES(STABLE_CYCLES),
        .CNT_W        (CNT_W)
    ) u_cnt (
        .i_clk (i_clk),
        .i_arst(i_arst),
        .i_clr (cnt_clr),
        .i_inc (cnt_inc),
        .o_term(cnt_term)
    );

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) state_q <= RST_STATE;
        else        state_q <= state_d;
    end

    // NOTE: state_d gets a default before the case so every path assigns it
    // and no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (i_en) begin
            unique case (state_q)
                S_LOW:      if (i_synced_bit)
                                state_d = (STABLE_CYCLES == 1) ? S_HIGH : S_CHK_HIGH;
                S_CHK_HIGH: if (!i_synced_bit) state_d = S_LOW;
                            else if (cnt_term) state_d = S_HIGH;
                S_HIGH:     if (!i_synced_bit)
                                state_d = (STABLE_CYCLES == 1) ? S_LOW : S_CHK_LOW;
                S_CHK_LOW:  if (i_synced_bit)  state_d = S_HIGH;
                            else if (cnt_term) state_d = S_LOW;
                default:    state_d = RST_STATE;
            endcase
        end
    end

    // Every counted sample lands in a CHK state; leaving one always clears.
    always_comb begin
        level_d = level_of(state_d);
        rise_d  = level_d && !level_of(state_q);
        fall_d  = !level_d && level_of(state_q);
        cnt_inc = i_en && is_chk(state_d);
        cnt_clr = i_en && is_chk(state_q) && !is_chk(state_d);
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            o_level <= RST_LEVEL;
            o_rise  <= 1'b0;
            o_fall  <= 1'b0;
        end else begin
            o_level <= level_d;
            o_rise  <= rise_d;
            o_fall  <= fall_d;
        end
    end

`ifdef DEBOUNCE_GLITCH_STATS_EN
    // A glitch is a check abandoned without a level change.
    logic glitch_ev;
    assign glitch_ev = cnt_clr && (level_of(state_d) == level_of(state_q));

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            o_glitch_cnt <= '0;
        end else if (glitch_ev && (o_glitch_cnt != '1)) begin
            o_glitch_cnt <= o_glitch_cnt + GLITCH_CNT_W'(1);
        end
    end
`else
    assign o_glitch_cnt = '0;
`endif

endmodule

// File: tb/tb_debounce_edge.sv
// Self-checking bench for debounce_edge: run-length reference model plus
// directed vectors with hand-computed expectations.
module tb_debounce_edge;

`ifdef DEBOUNCE_GLITCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       arst;
    logic       synced;
    logic       en;
    logic       level4, rise4, fall4;
    logic [7:0] glitch4;
    logic       level1, rise1, fall1;
    logic [7:0] glitch1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    debounce_edge #(.STABLE_CYCLES(4), .RST_LEVEL(1'b0)) dut4 (
        .i_clk(clk), .i_arst(arst), .i_synced_bit(synced), .i_en(en),
        .o_level(level4), .o_rise(rise4), .o_fall(fall4), .o_glitch_cnt(glitch4)
    );

    debounce_edge #(.STABLE_CYCLES(1), .RST_LEVEL(1'b1)) dut1 (
        .i_clk(clk), .i_arst(arst), .i_synced_bit(synced), .i_en(en),
        .o_level(level1), .o_rise(rise1), .o_fall(fall1), .o_glitch_cnt(glitch1)
    );

    // Model: the level flips once `sc` consecutive enabled samples disagree
    // with it; an interrupted disagreeing run is a glitch.
    typedef struct {
        bit level;
        bit rise;
        bit fall;
        int run;
        int glitch;
    } model_t;

    model_t m4, m1;

    function automatic model_t model_reset(input bit lvl);
        model_t m;
        m.level = lvl; m.rise = 0; m.fall = 0; m.run = 0; m.glitch = 0;
        return m;
    endfunction

    function automatic model_t model_step(input model_t m, input bit b, input bit e, input int sc);
        model_t n = m;
        n.rise = 0;
        n.fall = 0;
        if (e) begin
            if (b != m.level) begin
                n.run = m.run + 1;
                if (n.run == sc) begin
                    n.level = b;
                    n.rise  = b;
                    n.fall  = !b;
                    n.run   = 0;
                end
            end else begin
                if (m.run > 0 && STATS && n.glitch < 255) n.glitch = n.glitch + 1;
                n.run = 0;
            end
        end
        return n;
    endfunction

    always @(posedge clk or posedge arst) begin
        if (arst) begin
            m4 = model_reset(1'b0);
            m1 = model_reset(1'b1);
        end else begin
            m4 = model_step(m4, synced, en, 4);
            m1 = model_step(m1, synced, en, 1);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model, away from the active edge.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            check("m4_level",  {31'd0, level4}, {31'd0, m4.level});
            check("m4_rise",   {31'd0, rise4},  {31'd0, m4.rise});
            check("m4_fall",   {31'd0, fall4},  {31'd0, m4.fall});
            check("m4_glitch", {24'd0, glitch4}, 32'(m4.glitch));
            check("m1_level",  {31'd0, level1}, {31'd0, m1.level});
            check("m1_rise",   {31'd0, rise1},  {31'd0, m1.rise});
            check("m1_fall",   {31'd0, fall1},  {31'd0, m1.fall});
            check("m1_glitch", {24'd0, glitch1}, 32'(m1.glitch));
        end
    end

    task automatic cyc(input logic b, input logic e);
        synced = b;
        en     = e;
        @(negedge clk);
    endtask

    initial begin
        arst   = 1'b1;
        synced = 1'b1;
        en     = 1'b1;

        // Reset held with input high: outputs stay at reset values.
        repeat (3) @(negedge clk);
        check("rst_level4",  {31'd0, level4}, 32'd0);
        check("rst_rise4",   {31'd0, rise4},  32'd0);
        check("rst_glitch4", {24'd0, glitch4}, 32'd0);
        check("rst_level1",  {31'd0, level1}, 32'd1);
        arst = 1'b0;

        // Rise accepted on the 4th sample after release, single pulse.
        repeat (3) cyc(1'b1, 1'b1);
        check("t1_level_before", {31'd0, level4}, 32'd0);
        cyc(1'b1, 1'b1);
        check("t1_level_after", {31'd0, level4}, 32'd1);
        check("t1_rise",        {31'd0, rise4},  32'd1);
        cyc(1'b1, 1'b1);
        check("t2_rise_once",   {31'd0, rise4},  32'd0);
        repeat (5) cyc(1'b1, 1'b1);
        check("t2_no_fall",     {31'd0, fall4},  32'd0);

        // Back low, then a 3-sample glitch is rejected.
        repeat (3) cyc(1'b0, 1'b1);
        check("fall_not_yet",   {31'd0, level4}, 32'd1);
        cyc(1'b0, 1'b1);
        check("fall_pulse",     {31'd0, fall4},  32'd1);
        repeat (2) cyc(1'b0, 1'b1);
        repeat (3) cyc(1'b1, 1'b1);
        cyc(1'b0, 1'b1);
        check("t3_level",   {31'd0, level4}, 32'd0);
        check("t3_rise",    {31'd0, rise4},  32'd0);
        check("t3_glitch",  {24'd0, glitch4}, STATS ? 32'd1 : 32'd0);
        repeat (2) cyc(1'b0, 1'b1);

        // Check spanning disabled cycles resumes where it left off.
        repeat (2) cyc(1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0);
            check("t4_no_pulse", {31'd0, rise4}, 32'd0);
        end
        cyc(1'b1, 1'b1);
        check("t4_level_before", {31'd0, level4}, 32'd0);
        cyc(1'b1, 1'b1);
        check("t4_level_after",  {31'd0, level4}, 32'd1);
        check("t4_rise",         {31'd0, rise4},  32'd1);
        repeat (5) cyc(1'b0, 1'b1);

        // Single-cycle filter follows a toggling input one cycle late.
        for (int i = 0; i < 10; i++) begin
            logic b;
            b = (i % 2 == 0);
            cyc(b, 1'b1);
            check("t5_level1", {31'd0, level1}, {31'd0, b});
            check("t5_rise1",  {31'd0, rise1},  {31'd0, b});
            check("t5_fall1",  {31'd0, fall1},  {31'd0, !b});
        end
        repeat (5) cyc(1'b0, 1'b1);

        // 300 one-cycle glitches saturate the stats counter.
        for (int i = 0; i < 300; i++) begin
            cyc(1'b1, 1'b1);
            cyc(1'b0, 1'b1);
        end
        check("t6_sat", {24'd0, glitch4}, STATS ? 32'd255 : 32'd0);
        check("t6_level", {31'd0, level4}, 32'd0);

        // Async reset while checking in S_CHK_LOW.
        repeat (4) cyc(1'b1, 1'b1);
        check("t6_high", {31'd0, level4}, 32'd1);
        repeat (2) cyc(1'b0, 1'b1);
        #2 arst = 1'b1;
        #1;
        check("t6_arst_level4",  {31'd0, level4}, 32'd0);
        check("t6_arst_glitch4", {24'd0, glitch4}, 32'd0);
        check("t6_arst_level1",  {31'd0, level1}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        arst = 1'b0;
        repeat (4) cyc(1'b0, 1'b1);
        check("t6_post_level4", {31'd0, level4}, 32'd0);
        repeat (4) cyc(1'b1, 1'b1);
        check("t6_post_rise4",  {31'd0, rise4},  32'd1);
        repeat (2) cyc(1'b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/debounce_edge.md
Name: debounce_edge

Overview:
- Consumes the synchronized level produced by the upstream multi-flop synchronizer, which sits in the same clock domain.
- Filters glitches by requiring the input to hold STABLE_CYCLES consecutive sampled cycles before the debounced level changes.
- Emits single-cycle rise and fall pulses for downstream control logic such as UART start detection and button or handshake inputs.

Parameters:
- STABLE_CYCLES, 4: consecutive equal samples needed to accept a new level. Legal range 1..65535; elaboration error outside it.
- RST_LEVEL, 1'b0: debounced level and FSM stable state after reset.
- CNT_W (localparam), $clog2(STABLE_CYCLES+1): counter width.

Ports:
- i_clk  input  1  single clock, rising edge.
- i_arst  input  1  asynchronous, active-high reset.
- i_synced_bit  input  1  synchronized level from the upstream synchronizer output.
- i_en  input  1  sample enable; 0 freezes FSM and counter.
- o_level  output  1  debounced level.
- o_rise  output  1  one-cycle pulse on accepted 0->1.
- o_fall  output  1  one-cycle pulse on accepted 1->0.
- o_glitch_cnt  output  8  count of rejected transitions; see Optional Feature.

Behaviour:
- Reset (async assert, sync release):
  - o_level=RST_LEVEL, o_rise=0, o_fall=0, o_glitch_cnt=0, counter=0.
  - FSM goes to S_LOW if RST_LEVEL=0, otherwise S_HIGH.
  - Reset mid-check discards partial progress.
- FSM states: S_LOW, S_CHK_HIGH, S_HIGH, S_CHK_LOW. o_level=1 in S_HIGH and S_CHK_LOW only.
- S_LOW with i_en=1 and input=1:
  - STABLE_CYCLES=1: go straight to S_HIGH.
  - Otherwise: go to S_CHK_HIGH with cnt=1.
- S_CHK_HIGH with i_en=1:
  - input=0: back to S_LOW, cnt=0, glitch event.
  - input=1 and cnt==STABLE_CYCLES-1: go to S_HIGH, cnt=0.
  - Otherwise: cnt++.
- S_HIGH and S_CHK_LOW mirror the above with polarity inverted.
- Latency:
  - If the input is first sampled new at edge k and held through edge k+STABLE_CYCLES-1, o_level changes after edge k+STABLE_CYCLES-1.
  - o_rise/o_fall are high exactly that one cycle.
  - All outputs are registered.
- o_rise and o_fall are never high together and never high for two consecutive cycles.
- i_en=0:
  - State and cnt hold; o_rise=o_fall=0 that cycle.
  - A check spanning disabled cycles resumes counting when i_en returns.
  - Disabled cycles count neither as stable nor as glitch.
- A glitch of exactly STABLE_CYCLES-1 samples is rejected. A glitch of STABLE_CYCLES samples is accepted.
- Counter never exceeds STABLE_CYCLES-1; no wrap is possible.

Optional Feature:
- Macro: DEBOUNCE_GLITCH_STATS_EN.
- Defined:
  - o_glitch_cnt increments by 1 on every glitch event (return from a CHK state to its origin state).
  - Saturates at 8'hFF; holds until reset.
- Undefined: o_glitch_cnt tied to 8'h00; no counter logic is synthesized.

Decomposition:
- Package debounce_pkg:
  - typedef enum logic [1:0] state_t {S_LOW, S_CHK_HIGH, S_HIGH, S_CHK_LOW}.
  - Localparam GLITCH_CNT_W=8.
- Sub-module debounce_cnt: CNT_W-bit counter with clear, increment and terminal flag (cnt==STABLE_CYCLES-1).
- The FSM, output registers and stats counter stay in debounce_edge.

Test Plan:
1. Reset with RST_LEVEL=0, STABLE_CYCLES=4, input=1 during reset -> all outputs 0 while reset held; o_level=1 and o_rise pulse 4 cycles after release.
2. Input 0->1 held 10 cycles -> o_level rises after 4th high sample edge; o_rise high 1 cycle; o_fall stays 0.
3. Input high for 3 cycles then low (with stats macro) -> o_level stays 0, no pulses, o_glitch_cnt=1.
4. Input high 2 cycles, i_en=0 for 5 cycles, i_en=1 with input high 2 more cycles -> o_level rises after the 2nd enabled-again sample; no pulse during disabled cycles.
5. STABLE_CYCLES=1, input toggles every cycle -> o_level follows input delayed 1 cycle; alternating o_rise/o_fall pulses.
6. 300 glitches of 1 cycle each (with stats macro) -> o_glitch_cnt saturates at 8'hFF; async reset mid-check in S_CHK_LOW -> o_level=RST_LEVEL immediately, o_glitch_cnt=0.
